// File: rtl/dmem_slow_responder.sv
// Slow backing data memory behind the data cache: one request at a time,
// fixed LATENCY from accept to a single-cycle completion pulse.
module dmem_slow_responder #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 12,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_we,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy,
  output logic [STAT_W-1:0] stat_reads,
  output logic [STAT_W-1:0] stat_writes
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              resp_valid_q;
  logic              resp_we_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [STAT_W-1:0] stat_reads_q;
  logic [STAT_W-1:0] stat_writes_q;

  logic accept;
  logic commit;

  // Storage is deliberately outside the reset domain so contents survive rst.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only; no req_* to output path.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    accept    = req_valid && (state_q == S_IDLE);
    commit    = (state_q == S_WAIT) && (cnt_q == '0);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = CNT_LOAD;
    end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (commit && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_we_q     <= 1'b0;
      resp_rdata_q  <= '0;
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      resp_valid_q <= commit;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        resp_we_q <= we_q;
        // Reads see the array value before this edge; writes echo their data.
        resp_rdata_q <= we_q ? wdata_q : mem[addr_q];
        if (we_q) begin
          if (stat_writes_q != '1) stat_writes_q <= stat_writes_q + STAT_W'(1);
        end else begin
          if (stat_reads_q != '1) stat_reads_q <= stat_reads_q + STAT_W'(1);
        end
      end
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_we     = resp_we_q;
  assign resp_rdata  = resp_rdata_q;
  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;

endmodule

// File: tb/tb_dmem_slow_responder.sv
// Scoreboard bench: instance A (LATENCY=12) and instance B (LATENCY=1,
// STAT_W=4); accepted requests push expectations, negedge monitors check them.
module tb_dmem_slow_responder;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int LAT_A = 12;
  localparam int LAT_B = 1;
  localparam int SW_A  = 16;
  localparam int SW_B  = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            rst_a, a_valid, a_ready, a_we, a_resp_valid, a_resp_we, a_busy;
  logic [AW-1:0]   a_addr;
  logic [DW-1:0]   a_wdata, a_resp_rdata, a_exp;
  logic [SW_A-1:0] a_stat_reads, a_stat_writes;

  logic            rst_b, b_valid, b_ready, b_we, b_resp_valid, b_resp_we, b_busy;
  logic [AW-1:0]   b_addr;
  logic [DW-1:0]   b_wdata, b_resp_rdata, b_exp;
  logic [SW_B-1:0] b_stat_reads, b_stat_writes;

  dmem_slow_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT_A), .STAT_W(SW_A)) u_dut_a (
    .clk(clk), .rst(rst_a), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wdata), .resp_valid(a_resp_valid), .resp_we(a_resp_we),
    .resp_rdata(a_resp_rdata), .busy(a_busy), .stat_reads(a_stat_reads),
    .stat_writes(a_stat_writes)
  );

  dmem_slow_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT_B), .STAT_W(SW_B)) u_dut_b (
    .clk(clk), .rst(rst_b), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata), .resp_valid(b_resp_valid), .resp_we(b_resp_we),
    .resp_rdata(b_resp_rdata), .busy(b_busy), .stat_reads(b_stat_reads),
    .stat_writes(b_stat_writes)
  );

  int   checks = 0;
  int   errors = 0;
  int   acc_a  = 0;
  int   acc_b  = 0;
  int   last_acc_b = -1;
  bit   b_stream = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  function automatic void bound_expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got no event, required one", name);
  endfunction

  // Instance A monitor: compare responses, then record accepts.
  always @(negedge clk) begin
    if (rst_a) begin
      q_a.delete();
    end else begin
      if (a_resp_valid) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_resp", {63'b0, a_resp_valid}, 64'd0);
        end else begin
          ea = q_a.pop_front();
          $display("A resp we=%0b data=%08h cyc=%0d", a_resp_we, a_resp_rdata, cyc);
          chk("a_resp_we", {63'b0, a_resp_we}, {63'b0, ea.we});
          chk("a_resp_data", {32'b0, a_resp_rdata}, {32'b0, ea.data});
          chk("a_resp_cycle", 64'(cyc), 64'(ea.due));
        end
      end
      if (a_valid && a_ready) begin
        q_a.push_back('{we: a_we, data: a_exp, due: cyc + LAT_A + 1});
        acc_a++;
      end
    end
  end

  // Instance B monitor, plus accept spacing while streaming.
  always @(negedge clk) begin
    if (rst_b) begin
      q_b.delete();
    end else begin
      if (b_resp_valid) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_resp", {63'b0, b_resp_valid}, 64'd0);
        end else begin
          eb = q_b.pop_front();
          $display("B resp we=%0b data=%08h cyc=%0d", b_resp_we, b_resp_rdata, cyc);
          chk("b_resp_we", {63'b0, b_resp_we}, {63'b0, eb.we});
          chk("b_resp_data", {32'b0, b_resp_rdata}, {32'b0, eb.data});
          chk("b_resp_cycle", 64'(cyc), 64'(eb.due));
        end
      end
      if (b_valid && b_ready) begin
        q_b.push_back('{we: b_we, data: b_exp, due: cyc + LAT_B + 1});
        acc_b++;
        if (b_stream && last_acc_b >= 0) chk("b_accept_gap", 64'(cyc - last_acc_b), 64'(LAT_B + 2));
        last_acc_b = cyc;
      end
    end
  end

  task automatic wait_ready(input bit sel);
    int n = 0;
    forever begin
      @(negedge clk);
      if (sel ? b_ready : a_ready) break;
      n++;
      if (n > 200) begin
        bound_expired("accept_timeout");
        break;
      end
    end
  endtask

  task automatic issue(input bit sel, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [DW-1:0] ex);
    @(posedge clk); #1;
    if (!sel) begin
      a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_exp = ex;
    end else begin
      b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_exp = ex;
    end
    wait_ready(sel);
    @(posedge clk); #1;
    if (!sel) a_valid = 1'b0;
    else b_valid = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int n = 0;
    while ((sel ? q_b.size() : q_a.size()) > 0) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        bound_expired("drain_timeout");
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc0;
    rst_a = 1'b1; rst_b = 1'b1;
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_exp = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("a_rst_ready", {63'b0, a_ready}, 64'd1);
    chk("a_rst_busy", {63'b0, a_busy}, 64'd0);
    chk("a_rst_resp_valid", {63'b0, a_resp_valid}, 64'd0);
    chk("a_rst_resp_we", {63'b0, a_resp_we}, 64'd0);
    chk("a_rst_rdata", {32'b0, a_resp_rdata}, 64'd0);
    chk("a_rst_stats", {32'b0, a_stat_reads, a_stat_writes}, 64'd0);
    chk("b_rst_ready", {63'b0, b_ready}, 64'd1);
    chk("b_rst_stats", {56'b0, b_stat_reads, b_stat_writes}, 64'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Write then read back with full latency; ready stays low through WAIT+RESP.
    issue(0, 1'b1, 11'h005, 32'hDEADBEEF, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_busy", {63'b0, a_busy}, 64'd1);
    n = 0;
    while (!a_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("t1_ready_low_cycles", 64'(n), 64'd13);
    drain(0);
    issue(0, 1'b0, 11'h005, 32'h0, 32'hDEADBEEF);
    drain(0);

    // req_valid held through WAIT with a changing address.
    issue(0, 1'b1, 11'h030, 32'h30303030, 32'h30303030);
    drain(0);
    acc0 = acc_a;
    @(posedge clk); #1;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 11'h005; a_exp = 32'hDEADBEEF;
    wait_ready(0);
    @(posedge clk); #1;
    a_addr = 11'h123; a_exp = 32'h0BAD0BAD;
    repeat (6) @(posedge clk);
    #1;
    a_addr = 11'h030; a_exp = 32'h30303030;
    wait_ready(0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    drain(0);
    chk("t2_accepts", 64'(acc_a - acc0), 64'd2);

    // Same cache index, different tags.
    issue(0, 1'b1, 11'h015, 32'h11111111, 32'h11111111);
    issue(0, 1'b1, 11'h005, 32'h22222222, 32'h22222222);
    issue(0, 1'b0, 11'h015, 32'h0, 32'h11111111);
    issue(0, 1'b0, 11'h005, 32'h0, 32'h22222222);
    issue(0, 1'b1, 11'h405, 32'h44444444, 32'h44444444);
    issue(0, 1'b0, 11'h005, 32'h0, 32'h22222222);
    issue(0, 1'b0, 11'h405, 32'h0, 32'h44444444);
    drain(0);

    // Reset in the middle of a read's WAIT.
    issue(0, 1'b1, 11'h00A, 32'hCAFE0001, 32'hCAFE0001);
    drain(0);
    chk("t4_pre_writes", 64'(a_stat_writes), 64'd6);
    chk("t4_pre_reads", 64'(a_stat_reads), 64'd7);
    issue(0, 1'b0, 11'h00A, 32'h0, 32'hCAFE0001);
    repeat (4) @(posedge clk);
    #2 rst_a = 1'b1;
    #1;
    chk("t4_rst_resp_valid", {63'b0, a_resp_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_a = 1'b0;
    repeat (20) @(negedge clk);
    chk("t4_post_ready", {63'b0, a_ready}, 64'd1);
    chk("t4_post_reads", 64'(a_stat_reads), 64'd0);
    chk("t4_post_writes", 64'(a_stat_writes), 64'd0);
    issue(0, 1'b0, 11'h00A, 32'h0, 32'hCAFE0001);
    drain(0);
    chk("t4_reread_reads", 64'(a_stat_reads), 64'd1);

    // LATENCY=1 read stream with req_valid held high.
    for (int i = 0; i < 4; i++) issue(1, 1'b1, AW'(i), 32'hA0 + 32'(i), 32'hA0 + 32'(i));
    drain(1);
    b_stream = 1'b1;
    last_acc_b = -1;
    acc0 = acc_b;
    @(posedge clk); #1;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 11'h000; b_exp = 32'hA0;
    for (int i = 0; i < 4; i++) begin
      wait_ready(1);
      @(posedge clk); #1;
      if (i < 3) begin
        b_addr = AW'(i + 1);
        b_exp  = 32'hA1 + 32'(i);
      end else begin
        b_valid = 1'b0;
      end
    end
    drain(1);
    b_stream = 1'b0;
    chk("t5_accepts", 64'(acc_b - acc0), 64'd4);

    // Saturating counters on the 4-bit instance.
    @(posedge clk);
    #2 rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_b = 1'b0;
    chk("t6_rst_stats", {56'b0, b_stat_reads, b_stat_writes}, 64'd0);
    for (int i = 0; i < 3; i++) issue(1, 1'b1, 11'h010 + AW'(i), 32'h5 + 32'(i), 32'h5 + 32'(i));
    for (int i = 0; i < 17; i++) issue(1, 1'b0, AW'(i % 4), 32'h0, 32'hA0 + 32'(i % 4));
    drain(1);
    chk("t6_stat_reads", 64'(b_stat_reads), 64'd15);
    chk("t6_stat_writes", 64'(b_stat_writes), 64'd3);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
